// File: rtl/thermtrip_dly_mc_pkg.sv
// Shared definitions for the thermal-trip delay block.
//   trip_state_e    : delay FSM state encoding
//   CAUSE_CPU_BASE  : first cause bit used by the CPU THERMTRIP sources
//   cause_mem_base(): first cause bit used by the memory thermal events
//                     (it depends on the socket count, so it is a function)
package thermtrip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DELAY = 2'b01,
    TRIP  = 2'b10
  } trip_state_e;

  localparam int CAUSE_CPU_BASE = 0;

  function automatic int cause_mem_base(input int num_cpu);
    return num_cpu;
  endfunction

endpackage

// File: rtl/thermtrip_dly_mc_if.sv
// Pin bundle between the thermal pins / power sequencer and the delay block.
//   iCpuPwrgdDly    : delayed CPU power-good, gates the shutdown request
//   iThermtripN     : per-socket CPU THERMTRIP, active-low, asynchronous
//   iMemThermEventN : per-socket memory thermal event, active-low, asynchronous
//   iSktOccN        : per-socket occupied, active-low (socket 0 always present)
//   iClrLatch       : single-cycle clear of a latched trip
//   oThermtripDly   : delayed thermal-trip shutdown request
//   oTripActive     : OR of filtered, unmasked sources (before the delay)
//   oTripCause      : captured sources, CPU bits low, memory bits high
// master = pin/sequencer side, slave = the delay block.
interface thermtrip_dly_mc_if #(
  parameter int NUM_CPU = 2
);
  logic                   iCpuPwrgdDly;
  logic [NUM_CPU-1:0]     iThermtripN;
  logic [NUM_CPU-1:0]     iMemThermEventN;
  logic [NUM_CPU-1:0]     iSktOccN;
  logic                   iClrLatch;
  logic                   oThermtripDly;
  logic                   oTripActive;
  logic [2*NUM_CPU-1:0]   oTripCause;

  modport master (
    output iCpuPwrgdDly, iThermtripN, iMemThermEventN, iSktOccN, iClrLatch,
    input  oThermtripDly, oTripActive, oTripCause
  );

  modport slave (
    input  iCpuPwrgdDly, iThermtripN, iMemThermEventN, iSktOccN, iClrLatch,
    output oThermtripDly, oTripActive, oTripCause
  );
endinterface

// File: rtl/thermtrip_dly_mc_filt.sv
// One thermal source: 2-flop synchroniser followed by a glitch filter.
//   iClk_2M, iRst : clock, asynchronous active-high reset
//   src_n         : raw asynchronous source, active-low
//   qual          : source is allowed to count (socket present)
//   flag          : source accepted (held low FILT_CYC+ cycles)
// With FILT_CYC = 0 the flag simply follows the qualified synchronised source.
module thermtrip_filt #(
  parameter int FILT_CYC = 2
) (
  input  logic iClk_2M,
  input  logic iRst,
  input  logic src_n,
  input  logic qual,
  output logic flag
);

  logic [1:0] sync_n;
  logic       src_active;

  // NOTE: synchroniser flops reset to 1 so a source reads as deasserted
  // until real pin levels have propagated through both stages.
  always_ff @(posedge iClk_2M or posedge iRst) begin
    if (iRst) begin
      sync_n <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments make sync_n[1] take the old sync_n[0],
      // which is what gives two stages rather than one.
      sync_n <= {sync_n[0], src_n};
    end
  end

  assign src_active = ~sync_n[1] & qual;

  if (FILT_CYC == 0) begin : g_bypass
    always_ff @(posedge iClk_2M or posedge iRst) begin
      if (iRst) flag <= 1'b0;
      else      flag <= src_active;
    end
  end else begin : g_filter
    localparam int              CW       = $clog2(FILT_CYC + 1);
    localparam logic [CW-1:0]   FILT_MAX = CW'(FILT_CYC);

    logic [CW-1:0] cnt;

    // The count saturates at FILT_CYC, so "cnt == FILT_MAX" means the source
    // has been seen asserted for at least FILT_CYC consecutive cycles.
    always_ff @(posedge iClk_2M or posedge iRst) begin
      if (iRst) begin
        cnt  <= '0;
        flag <= 1'b0;
      end else if (!src_active) begin
        cnt  <= '0;
        flag <= 1'b0;
      end else begin
        if (cnt != FILT_MAX) cnt <= cnt + 1'b1;
        flag <= (cnt == FILT_MAX);
      end
    end
  end

endmodule

// File: rtl/thermtrip_dly_mc.sv
// Multi-socket thermal-trip delay. Filters CPU and memory thermal sources,
// masks absent sockets, holds the shutdown request off for DLY_CYC cycles so
// the BMC can log the event, optionally latches the trip and records causes.
//   iClk_2M : 2 MHz clock
//   iRst    : asynchronous active-high reset
//   bus     : thermtrip_dly_mc_if.slave (pins, clear, outputs)
module thermtrip_dly_mc
  import thermtrip_pkg::*;
#(
  parameter int NUM_CPU  = 2,
  parameter int DLY_CYC  = 200,
  parameter int FILT_CYC = 2,
  parameter int LATCH_EN = 1
) (
  input logic               iClk_2M,
  input logic               iRst,
  thermtrip_dly_mc_if.slave bus
);

  localparam int            NSRC     = 2 * NUM_CPU;
  localparam int            MEM_BASE = cause_mem_base(NUM_CPU);
  localparam int            DCW      = $clog2(DLY_CYC + 1);
  localparam logic [DCW-1:0] DLY_LAST = DCW'(DLY_CYC - 1);

  logic [NUM_CPU-1:0] skt_s1_n, skt_s2_n, present;
  logic [NSRC-1:0]    filt;
  logic               any_trip;
  trip_state_e        state;
  logic [DCW-1:0]     dly_cnt;
  logic [NSRC-1:0]    cause;
  logic               trip_active;

  always_ff @(posedge iClk_2M or posedge iRst) begin
    if (iRst) begin
      skt_s1_n <= '1;
      skt_s2_n <= '1;
    end else begin
      skt_s1_n <= bus.iSktOccN;
      skt_s2_n <= skt_s1_n;
    end
  end

  // NOTE: every bit is assigned from a default first, so no latch is inferred.
  always_comb begin
    present    = ~skt_s2_n;
    present[0] = 1'b1;
  end

  for (genvar i = 0; i < NUM_CPU; i++) begin : g_src
    thermtrip_filt #(.FILT_CYC(FILT_CYC)) u_cpu (
      .iClk_2M (iClk_2M),
      .iRst    (iRst),
      .src_n   (bus.iThermtripN[i]),
      .qual    (present[i]),
      .flag    (filt[CAUSE_CPU_BASE + i])
    );
    thermtrip_filt #(.FILT_CYC(FILT_CYC)) u_mem (
      .iClk_2M (iClk_2M),
      .iRst    (iRst),
      .src_n   (bus.iMemThermEventN[i]),
      .qual    (present[i]),
      .flag    (filt[MEM_BASE + i])
    );
  end

  assign any_trip = |filt;

  // dly_cnt counts cycles since any_trip rose, the IDLE->DELAY edge being 1,
  // so TRIP is entered exactly DLY_CYC edges after any_trip asserts.
  // In DELAY the abort test comes first: a drop on the last count wins.
  always_ff @(posedge iClk_2M or posedge iRst) begin
    if (iRst) begin
      state       <= IDLE;
      dly_cnt     <= '0;
      cause       <= '0;
      trip_active <= 1'b0;
    end else begin
      trip_active <= any_trip;
      case (state)
        IDLE: begin
          dly_cnt <= '0;
          if (any_trip) begin
            cause   <= filt;
            dly_cnt <= DCW'(1);
            state   <= (DLY_CYC == 1) ? TRIP : DELAY;
          end
        end
        DELAY: begin
          if (!any_trip) begin
            state   <= IDLE;
            dly_cnt <= '0;
            cause   <= '0;
          end else begin
            cause <= cause | filt;
            if (dly_cnt == DLY_LAST) state <= TRIP;
            else                     dly_cnt <= dly_cnt + 1'b1;
          end
        end
        TRIP: begin
          // Sticky mode leaves only once sources are gone and either software
          // clears it or the CPU rail has already dropped.
          if (!any_trip &&
              ((LATCH_EN == 0) || bus.iClrLatch || !bus.iCpuPwrgdDly)) begin
            state   <= IDLE;
            dly_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oThermtripDly = (state == TRIP) & bus.iCpuPwrgdDly;
  assign bus.oTripActive   = trip_active;
  assign bus.oTripCause    = cause;

endmodule

// File: tb/tb_thermtrip_dly_mc.sv
`timescale 1ns/1ps
module tb_thermtrip_dly_mc;

  typedef struct {
    int         cyc;
    logic       dly;
    logic       act;
    logic [3:0] cause;
    logic       dly_nl;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;
  ev_t  exp_q[$];
  logic [6:0] prev_o;
  bit   mon_en = 1'b0;

  thermtrip_dly_mc_if #(.NUM_CPU(2)) bus ();
  thermtrip_dly_mc_if #(.NUM_CPU(2)) bus_nl ();

  assign bus_nl.iCpuPwrgdDly    = bus.iCpuPwrgdDly;
  assign bus_nl.iThermtripN     = bus.iThermtripN;
  assign bus_nl.iMemThermEventN = bus.iMemThermEventN;
  assign bus_nl.iSktOccN        = bus.iSktOccN;
  assign bus_nl.iClrLatch       = bus.iClrLatch;

  thermtrip_dly_mc #(.NUM_CPU(2), .DLY_CYC(200), .FILT_CYC(2), .LATCH_EN(1)) dut (
    .iClk_2M (clk),
    .iRst    (rst),
    .bus     (bus)
  );

  thermtrip_dly_mc #(.NUM_CPU(2), .DLY_CYC(200), .FILT_CYC(2), .LATCH_EN(0)) dut_nl (
    .iClk_2M (clk),
    .iRst    (rst),
    .bus     (bus_nl)
  );

  always #250 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [6:0] outs();
    return {bus.oThermtripDly, bus.oTripActive, bus.oTripCause, bus_nl.oThermtripDly};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, edge_cnt);
    end
  endtask

  task automatic expect_ev(input int cyc, input logic dly, input logic act,
                           input logic [3:0] cause, input logic dly_nl);
    ev_t e;
    e.cyc = cyc; e.dly = dly; e.act = act; e.cause = cause; e.dly_nl = dly_nl;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every change of the observed outputs is one DUT event; it must
  // match the oldest expected event in both value and edge number.
  always @(negedge clk) begin
    logic [6:0] cur;
    ev_t e;
    if (mon_en) begin
      cur = outs();
      if (cur !== prev_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_change", {25'd0, cur}, {25'd0, prev_o});
        end else begin
          e = exp_q.pop_front();
          check("event_edge", edge_cnt, e.cyc);
          check("event_value", {25'd0, cur}, {25'd0, e.dly, e.act, e.cause, e.dly_nl});
        end
        prev_o = cur;
      end
    end
  end

  initial begin
    int c, n;
    rst = 1'b1;
    bus.iCpuPwrgdDly    = 1'b1;
    bus.iThermtripN     = 2'b11;
    bus.iMemThermEventN = 2'b11;
    bus.iSktOccN        = 2'b11;
    bus.iClrLatch       = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);
    check("reset_state", {25'd0, outs()}, 32'd0);
    prev_o = outs();
    mon_en = 1'b1;

    // CPU0 trip with latch, release, then software clear
    c = edge_cnt; bus.iThermtripN[0] = 1'b0;
    expect_ev(c + 6,   0, 1, 4'b0001, 0);
    expect_ev(c + 205, 1, 1, 4'b0001, 1);
    step(210);
    c = edge_cnt; bus.iThermtripN[0] = 1'b1;
    expect_ev(c + 4, 1, 0, 4'b0001, 0);
    step(10);
    c = edge_cnt; bus.iClrLatch = 1'b1;
    expect_ev(c + 1, 0, 0, 4'b0001, 0);
    step(1); bus.iClrLatch = 1'b0;
    step(5);

    // CPU1 with socket absent: nothing; then with socket present
    bus.iThermtripN[1] = 1'b0;
    step(20);
    bus.iThermtripN[1] = 1'b1; bus.iSktOccN[1] = 1'b0;
    step(10);
    c = edge_cnt; bus.iThermtripN[1] = 1'b0;
    expect_ev(c + 6,   0, 1, 4'b0010, 0);
    expect_ev(c + 205, 1, 1, 4'b0010, 1);
    step(210);
    c = edge_cnt; bus.iThermtripN[1] = 1'b1;
    expect_ev(c + 4, 1, 0, 4'b0010, 0);
    step(10);

    // clear arriving together with a newly filtered source is ignored
    c = edge_cnt; bus.iThermtripN[0] = 1'b0;
    step(5); bus.iClrLatch = 1'b1;
    expect_ev(c + 6,   1, 1, 4'b0010, 0);
    expect_ev(c + 205, 1, 1, 4'b0010, 1);
    step(1); bus.iClrLatch = 1'b0;
    step(215);

    // power-good gates the request combinationally
    n = edge_cnt; bus.iCpuPwrgdDly = 1'b0;
    expect_ev(n, 0, 1, 4'b0010, 0);
    step(3);
    n = edge_cnt; bus.iCpuPwrgdDly = 1'b1;
    expect_ev(n, 1, 1, 4'b0010, 1);
    step(3);
    c = edge_cnt; bus.iThermtripN[0] = 1'b1;
    expect_ev(c + 4, 1, 0, 4'b0010, 0);
    step(10);
    // latched trip also leaves TRIP when power-good drops with sources gone
    n = edge_cnt; bus.iCpuPwrgdDly = 1'b0;
    expect_ev(n, 0, 0, 4'b0010, 0);
    step(3); bus.iCpuPwrgdDly = 1'b1;
    step(5);

    // one-cycle glitch on memory event 0 is filtered out
    bus.iMemThermEventN[0] = 1'b0;
    step(1); bus.iMemThermEventN[0] = 1'b1;
    step(15);

    // release at delay cycle 150 aborts; reassert restarts the full delay
    c = edge_cnt; bus.iThermtripN[0] = 1'b0;
    expect_ev(c + 6, 0, 1, 4'b0001, 0);
    step(156);
    c = edge_cnt; bus.iThermtripN[0] = 1'b1;
    expect_ev(c + 4, 0, 0, 4'b0000, 0);
    step(14);
    c = edge_cnt; bus.iThermtripN[0] = 1'b0;
    expect_ev(c + 6,   0, 1, 4'b0001, 0);
    expect_ev(c + 205, 1, 1, 4'b0001, 1);
    step(210);
    c = edge_cnt; bus.iThermtripN[0] = 1'b1;
    expect_ev(c + 4, 1, 0, 4'b0001, 0);
    step(6);
    c = edge_cnt; bus.iClrLatch = 1'b1;
    expect_ev(c + 1, 0, 0, 4'b0001, 0);
    step(1); bus.iClrLatch = 1'b0;
    step(5);

    // source drops on the very last delay count: abort wins
    c = edge_cnt; bus.iThermtripN[0] = 1'b0;
    expect_ev(c + 6,   0, 1, 4'b0001, 0);
    expect_ev(c + 205, 0, 0, 4'b0000, 0);
    step(201); bus.iThermtripN[0] = 1'b1;
    step(15);

    // socket 1 vacated mid-delay masks its only source and aborts
    c = edge_cnt; bus.iThermtripN[1] = 1'b0;
    expect_ev(c + 6, 0, 1, 4'b0010, 0);
    step(50); bus.iSktOccN[1] = 1'b1;
    expect_ev(c + 54, 0, 0, 4'b0000, 0);
    step(10); bus.iThermtripN[1] = 1'b1;
    step(5);

    // asynchronous reset in the middle of DELAY
    c = edge_cnt; bus.iThermtripN[0] = 1'b0;
    expect_ev(c + 6, 0, 1, 4'b0001, 0);
    step(40);
    n = edge_cnt; rst = 1'b1;
    expect_ev(n, 0, 0, 4'b0000, 0);
    #1;
    check("reset_async", {25'd0, outs()}, 32'd0);
    bus.iThermtripN[0] = 1'b1;
    step(3); rst = 1'b0;
    step(10);

    check("events_outstanding", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
